// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the MEM/WB stage: datapath width,
// writeback source selector and load funct3 encodings.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle between the memory stage, the MEM/WB register and the writeback mux.
// master drives the memory-stage side, slave is the stage register itself.
interface mem_wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    import riscv_pkg::*;

    logic              stall;
    logic              flush;
    logic              valid_i;
    logic [XLEN-1:0]   alu_result_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic [XLEN-1:0]   pc_plus4_i;
    logic [XLEN-1:0]   imm_ext_i;
    result_src_t       result_src_i;
    logic [2:0]        funct3_i;
    logic [4:0]        rd_i;
    logic              reg_write_i;

    logic              valid_o;
    logic [XLEN-1:0]   alu_result_o;
    logic [XLEN-1:0]   load_data_o;
    logic [XLEN-1:0]   pc_plus4_o;
    logic [XLEN-1:0]   imm_ext_o;
    result_src_t       result_src_o;
    logic [4:0]        rd_o;
    logic              reg_write_o;
    logic              misaligned_o;
    logic [CNT_W-1:0]  instret_o;

    modport master (
        output stall, flush, valid_i, alu_result_i, mem_rdata_i, pc_plus4_i,
               imm_ext_i, result_src_i, funct3_i, rd_i, reg_write_i,
        input  valid_o, alu_result_o, load_data_o, pc_plus4_o, imm_ext_o,
               result_src_o, rd_o, reg_write_o, misaligned_o, instret_o
    );

    modport slave (
        input  stall, flush, valid_i, alu_result_i, mem_rdata_i, pc_plus4_i,
               imm_ext_i, result_src_i, funct3_i, rd_i, reg_write_i,
        output valid_o, alu_result_o, load_data_o, pc_plus4_o, imm_ext_o,
               result_src_o, rd_o, reg_write_o, misaligned_o, instret_o
    );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load alignment: picks the addressed byte/half out of the raw
// memory word, sign- or zero-extends it, and flags addresses that are not size-aligned.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            mis
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        byte_sel = 8'sd0;
        unique case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'sd0;
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Signed casts sign-extend; $unsigned forces zero extension for LBU/LHU.
    always_comb begin
        data = rdata;
        mis  = 1'b0;
        case (funct3)
            F3_LB: begin
                data = XLEN'(byte_sel);
            end
            F3_LBU: begin
                data = XLEN'($unsigned(byte_sel));
            end
            F3_LH: begin
                data = XLEN'(half_sel);
                mis  = off[0];
            end
            F3_LHU: begin
                data = XLEN'($unsigned(half_sel));
                mis  = off[0];
            end
            F3_LW: begin
                data = rdata;
                mis  = (off != 2'd0);
            end
            default: begin
                data = rdata;
                mis  = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the RV32I core: registers the four writeback
// candidates and control, suppresses misaligned loads, and counts retired instructions.
module mem_wb_stage #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);
    import riscv_pkg::*;

    logic [XLEN-1:0]  ld_data;
    logic             ld_mis;
    logic             mis;
    logic             retire;

    logic             vld_p1;
    logic [XLEN-1:0]  alu_result_p1;
    logic [XLEN-1:0]  load_data_p1;
    logic [XLEN-1:0]  pc_plus4_p1;
    logic [XLEN-1:0]  imm_ext_p1;
    result_src_t      result_src_p1;
    logic [4:0]       rd_p1;
    logic             reg_write_p1;
    logic             mis_p1;
    logic [CNT_W-1:0] instret_p1;

    load_extend u_load_extend (
        .rdata  (bus.mem_rdata_i),
        .off    (bus.alu_result_i[1:0]),
        .funct3 (bus.funct3_i),
        .data   (ld_data),
        .mis    (ld_mis)
    );

    // Alignment only matters for real instructions that write back load data.
    assign mis    = bus.valid_i && (bus.result_src_i == RES_MEM) && ld_mis;
    assign retire = bus.valid_i && !mis;

    // MEM -> WB boundary: rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            alu_result_p1 <= '0;
            load_data_p1  <= '0;
            pc_plus4_p1   <= '0;
            imm_ext_p1    <= '0;
            result_src_p1 <= RES_ALU;
            rd_p1         <= '0;
            reg_write_p1  <= 1'b0;
            mis_p1        <= 1'b0;
            instret_p1    <= '0;
        end else if (bus.flush) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mis_p1       <= 1'b0;
        end else if (!bus.stall) begin
            vld_p1        <= bus.valid_i;
            alu_result_p1 <= bus.alu_result_i;
            load_data_p1  <= ld_data;
            pc_plus4_p1   <= bus.pc_plus4_i;
            imm_ext_p1    <= bus.imm_ext_i;
            result_src_p1 <= bus.result_src_i;
            rd_p1         <= bus.rd_i;
            reg_write_p1  <= bus.reg_write_i && bus.valid_i && !mis;
            mis_p1        <= mis;
            if (retire) begin
                instret_p1 <= instret_p1 + CNT_W'(1);
            end
        end
    end

    assign bus.valid_o      = vld_p1;
    assign bus.alu_result_o = alu_result_p1;
    assign bus.load_data_o  = load_data_p1;
    assign bus.pc_plus4_o   = pc_plus4_p1;
    assign bus.imm_ext_o    = imm_ext_p1;
    assign bus.result_src_o = result_src_p1;
    assign bus.rd_o         = rd_p1;
    assign bus.reg_write_o  = reg_write_p1;
    assign bus.misaligned_o = mis_p1;
    assign bus.instret_o    = instret_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference model queues the expected
// register contents per cycle; a monitor pops and compares after each clock edge.
module tb_mem_wb_stage;
    import riscv_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] alu, rdata, pc4, imm;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] alu, ld, pc4, imm;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic        rw, mis;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t st;
    exp_t q[$];
    exp_t mon_e;

    mem_wb_stage_if #(.XLEN(32), .CNT_W(CNT_W)) bus ();

    mem_wb_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == F3_LB || f3 == F3_LBU) return 1;
        if (f3 == F3_LH || f3 == F3_LHU) return 2;
        return 4;
    endfunction

    // Memory-side view: take the size-aligned field containing the address, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [2:0] f3);
        int     size;
        int     sh;
        longint v;
        longint mask;
        size = access_size(f3);
        if (size == 4) return w;
        sh   = 8 * (off - off % size);
        mask = (longint'(1) << (8 * size)) - 1;
        v    = (longint'(w) >> sh) & mask;
        if ((f3 == F3_LB || f3 == F3_LH) && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    function automatic void model(input stim_t s);
        int off;
        bit misal;
        off = int'(s.alu[1:0]);
        misal = s.valid && s.src == 2'b01 && (off % access_size(s.f3) != 0);
        if (s.rst) begin
            st = '{valid: 0, alu: 0, ld: 0, pc4: 0, imm: 0, src: 0, rd: 0, rw: 0, mis: 0, cnt: 0};
        end else if (s.flush) begin
            st.valid = 0;
            st.rw    = 0;
            st.mis   = 0;
        end else if (!s.stall) begin
            st.valid = s.valid;
            st.alu   = s.alu;
            st.ld    = ref_load(s.rdata, off, s.f3);
            st.pc4   = s.pc4;
            st.imm   = s.imm;
            st.src   = s.src;
            st.rd    = s.rd;
            st.rw    = s.rw && s.valid && !misal;
            st.mis   = misal;
            if (s.valid && !misal) st.cnt = (st.cnt + 1) % (1 << CNT_W);
        end
        q.push_back(st);
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst                = s.rst;
        bus.stall          = s.stall;
        bus.flush          = s.flush;
        bus.valid_i        = s.valid;
        bus.alu_result_i   = s.alu;
        bus.mem_rdata_i    = s.rdata;
        bus.pc_plus4_i     = s.pc4;
        bus.imm_ext_i      = s.imm;
        bus.result_src_i   = result_src_t'(s.src);
        bus.funct3_i       = s.f3;
        bus.rd_i           = s.rd;
        bus.reg_write_i    = s.rw;
        model(s);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 0, stall: 0, flush: 0, valid: 0, alu: 0, rdata: 0, pc4: 0, imm: 0,
              src: 0, f3: 0, rd: 0, rw: 0};
        return s;
    endfunction

    function automatic stim_t ld(input logic [2:0] f3, input logic [1:0] off,
                                 input logic [31:0] rdata, input logic [4:0] rd);
        stim_t s;
        s       = idle();
        s.valid = 1;
        s.rw    = 1;
        s.src   = 2'b01;
        s.f3    = f3;
        s.alu   = {30'h0400_0000, off};
        s.rdata = rdata;
        s.pc4   = 32'h0000_1004;
        s.imm   = 32'h0001_2000;
        s.rd    = rd;
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("valid_o",      64'(bus.valid_o),      64'(mon_e.valid));
            chk("alu_result_o", 64'(bus.alu_result_o), 64'(mon_e.alu));
            chk("load_data_o",  64'(bus.load_data_o),  64'(mon_e.ld));
            chk("pc_plus4_o",   64'(bus.pc_plus4_o),   64'(mon_e.pc4));
            chk("imm_ext_o",    64'(bus.imm_ext_o),    64'(mon_e.imm));
            chk("result_src_o", 64'(bus.result_src_o), 64'(mon_e.src));
            chk("rd_o",         64'(bus.rd_o),         64'(mon_e.rd));
            chk("reg_write_o",  64'(bus.reg_write_o),  64'(mon_e.rw));
            chk("misaligned_o", 64'(bus.misaligned_o), 64'(mon_e.mis));
            chk("instret_o",    64'(bus.instret_o),    64'(mon_e.cnt));
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        bus.stall = 0; bus.flush = 0; bus.valid_i = 0; bus.alu_result_i = 0;
        bus.mem_rdata_i = 0; bus.pc_plus4_i = 0; bus.imm_ext_i = 0;
        bus.result_src_i = RES_ALU; bus.funct3_i = 0; bus.rd_i = 0; bus.reg_write_i = 0;

        s = idle(); s.rst = 1;
        drive(s);
        drive(s);
        drive(idle());
        settle();
        chk("reset_valid",   64'(bus.valid_o),     64'd0);
        chk("reset_load",    64'(bus.load_data_o), 64'd0);
        chk("reset_rw",      64'(bus.reg_write_o), 64'd0);
        chk("reset_instret", 64'(bus.instret_o),   64'd0);

        drive(ld(F3_LB, 2'd3, 32'h80FF_7F01, 5'd1));
        settle();
        chk("lb_off3", 64'(bus.load_data_o), 64'hFFFF_FF80);
        drive(ld(F3_LB, 2'd1, 32'h80FF_7F01, 5'd2));
        settle();
        chk("lb_off1", 64'(bus.load_data_o), 64'h0000_007F);
        drive(ld(F3_LBU, 2'd2, 32'h80FF_7F01, 5'd3));
        settle();
        chk("lbu_off2", 64'(bus.load_data_o), 64'h0000_00FF);
        chk("instret_3", 64'(bus.instret_o), 64'd3);

        drive(ld(F3_LH, 2'd2, 32'h8001_1234, 5'd4));
        settle();
        chk("lh_off2", 64'(bus.load_data_o), 64'hFFFF_8001);
        chk("instret_4", 64'(bus.instret_o), 64'd4);
        drive(ld(F3_LH, 2'd1, 32'h8001_1234, 5'd4));
        settle();
        chk("lh_mis",         64'(bus.misaligned_o), 64'd1);
        chk("lh_mis_rw",      64'(bus.reg_write_o),  64'd0);
        chk("lh_mis_instret", 64'(bus.instret_o),    64'd4);
        drive(idle());
        settle();
        chk("mis_one_cycle", 64'(bus.misaligned_o), 64'd0);

        drive(ld(F3_LW, 2'd0, 32'hCAFE_F00D, 5'd5));
        settle();
        chk("rd5", 64'(bus.rd_o), 64'd5);
        for (int i = 0; i < 3; i++) begin
            s = ld(F3_LW, 2'd0, 32'h1111_0000 + 32'(i), 5'd9);
            s.stall = 1;
            drive(s);
            settle();
            chk("stall_rd",      64'(bus.rd_o),      64'd5);
            chk("stall_instret", 64'(bus.instret_o), 64'd5);
        end
        drive(ld(F3_LW, 2'd0, 32'h2222_0000, 5'd9));
        settle();
        chk("release_rd", 64'(bus.rd_o), 64'd9);

        s = ld(F3_LW, 2'd0, 32'h3333_0000, 5'd7);
        s.stall = 1;
        s.flush = 1;
        drive(s);
        settle();
        chk("flush_valid",   64'(bus.valid_o),     64'd0);
        chk("flush_rw",      64'(bus.reg_write_o), 64'd0);
        chk("flush_instret", 64'(bus.instret_o),   64'd6);

        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(63) == 0);
            s.stall = ($urandom_range(4) == 0);
            s.flush = ($urandom_range(7) == 0);
            s.valid = ($urandom_range(3) != 0);
            s.alu   = $urandom;
            s.rdata = $urandom;
            s.pc4   = $urandom;
            s.imm   = $urandom;
            s.src   = 2'($urandom_range(3));
            s.f3    = 3'($urandom_range(7));
            s.rd    = 5'($urandom_range(31));
            s.rw    = 1'($urandom_range(1));
            drive(s);
        end

        s = idle(); s.rst = 1;
        drive(s);
        for (int i = 0; i < 15; i++) drive(ld(F3_LW, 2'd0, 32'h0000_0000 + 32'(i), 5'd1));
        settle();
        chk("instret_max", 64'(bus.instret_o), 64'd15);
        drive(ld(F3_LW, 2'd0, 32'h5555_AAAA, 5'd1));
        settle();
        chk("instret_wrap", 64'(bus.instret_o), 64'd0);

        drive(idle());
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
